// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types; also carries the L1 SRAM sequencer state encoding
// so the cache controller and the bench can decode it.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    READ     = 3'd2,
    READ_CAP = 3'd3,
    DONE     = 3'd4
  } l1_sram_ctrl_state_t;

endpackage

// File: rtl/l1_sram_ctrl_if.sv
// Block request/response and SRAM-wrapper signals of the L1 SRAM sequencer.
// master: cache FSM plus SRAM wrapper side; slave: the sequencer.
interface l1_sram_ctrl_if #(
  parameter int N_FRAME_BITS = 1,
  parameter int N_SET_BITS   = 6,
  parameter int BLOCK_SIZE   = 2,
  parameter int N_BLOCK_BITS = 1
);
  import rv32i_types_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [N_SET_BITS-1:0]      req_set;
  logic [N_FRAME_BITS-1:0]    req_frame;
  logic [BLOCK_SIZE-1:0]      req_wmask;
  logic [BLOCK_SIZE*32-1:0]   req_wdata;
  logic                       rsp_valid;
  logic [BLOCK_SIZE*32-1:0]   rsp_rdata;
  logic [N_SET_BITS-1:0]      sram_set_bits;
  logic [N_FRAME_BITS-1:0]    sram_frame_bits;
  logic                       sram_cs;
  logic                       sram_we;
  logic                       sram_oe;
  logic [N_BLOCK_BITS-1:0]    sram_word_num;
  word_t                      sram_wdata;
  logic [BLOCK_SIZE*32-1:0]   sram_rdata;
  logic                       sram_busy;

  modport master (
    output req_valid, req_write, req_set, req_frame, req_wmask, req_wdata,
           sram_rdata, sram_busy,
    input  req_ready, rsp_valid, rsp_rdata,
           sram_set_bits, sram_frame_bits, sram_cs, sram_we, sram_oe,
           sram_word_num, sram_wdata
  );

  modport slave (
    input  req_valid, req_write, req_set, req_frame, req_wmask, req_wdata,
           sram_rdata, sram_busy,
    output req_ready, rsp_valid, rsp_rdata,
           sram_set_bits, sram_frame_bits, sram_cs, sram_we, sram_oe,
           sram_word_num, sram_wdata
  );

endinterface

// File: rtl/l1_sram_word_sel.sv
// Lowest-set-bit priority encoder over a block write mask; purely combinational.
module l1_sram_word_sel #(
  parameter int BLOCK_SIZE   = 2,
  parameter int N_BLOCK_BITS = 1
) (
  input  logic [BLOCK_SIZE-1:0]   mask,
  output logic [N_BLOCK_BITS-1:0] idx,
  output logic                    any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan downward so the lowest set bit is the last one to win.
    for (int i = BLOCK_SIZE - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = N_BLOCK_BITS'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_sram_ctrl.sv
// Sequences one block request into word-serial SRAM beats; k-word write responds in cycle k+1,
// read in cycle 3; sram_busy stretches the current beat, requests wait while req_ready is low.
module l1_sram_ctrl
  import rv32i_types_pkg::*;
#(
  parameter int ASSOC        = 1,
  parameter int N_FRAME_BITS = (ASSOC > 1) ? $clog2(ASSOC) : 1,
  parameter int N_SETS       = 512,
  parameter int N_SET_BITS   = 6,
  parameter int BLOCK_SIZE   = 2,
  parameter int N_BLOCK_BITS = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
  input logic           CLK,
  input logic           nRST,
  l1_sram_ctrl_if.slave bus
);

  l1_sram_ctrl_state_t        state;
  logic [N_SET_BITS-1:0]      set_q;
  logic [N_FRAME_BITS-1:0]    frame_q;
  logic [BLOCK_SIZE-1:0]      mask_q;
  word_t [BLOCK_SIZE-1:0]     wdata_q;
  logic [N_BLOCK_BITS-1:0]    idx_q;
  word_t                      wword_q;
  logic [BLOCK_SIZE*32-1:0]   rdata_q;
  logic                       ready_q;
  logic                       rsp_valid_q;
  logic                       cs_q;
  logic                       we_q;
  logic                       oe_q;

  word_t [BLOCK_SIZE-1:0]     req_words;
  logic [BLOCK_SIZE-1:0]      mask_rem;
  logic [BLOCK_SIZE-1:0]      sel_in;
  logic [N_BLOCK_BITS-1:0]    sel_idx;
  logic                       sel_any;

  assign req_words = bus.req_wdata;
  assign mask_rem  = mask_q & ~(BLOCK_SIZE'(1) << idx_q);
  // One encoder serves both the first index at accept and each following index.
  assign sel_in    = (state == IDLE) ? bus.req_wmask : mask_rem;

  l1_sram_word_sel #(
    .BLOCK_SIZE   (BLOCK_SIZE),
    .N_BLOCK_BITS (N_BLOCK_BITS)
  ) u_word_sel (
    .mask (sel_in),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  always_ff @(posedge CLK, posedge nRST) begin
    if (nRST) begin
      state       <= IDLE;
      set_q       <= '0;
      frame_q     <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      wword_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            set_q   <= bus.req_set;
            frame_q <= bus.req_frame;
            mask_q  <= bus.req_wmask;
            wdata_q <= req_words;
            if (!bus.req_write) begin
              state <= READ;
              cs_q  <= 1'b1;
              oe_q  <= 1'b1;
              idx_q <= '0;
            end else if (sel_any) begin
              state   <= WRITE;
              cs_q    <= 1'b1;
              we_q    <= 1'b1;
              idx_q   <= sel_idx;
              wword_q <= req_words[sel_idx];
            end else begin
              state       <= DONE;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (!bus.sram_busy) begin
            mask_q <= mask_rem;
            if (sel_any) begin
              idx_q   <= sel_idx;
              wword_q <= wdata_q[sel_idx];
            end else begin
              state       <= DONE;
              cs_q        <= 1'b0;
              we_q        <= 1'b0;
              idx_q       <= '0;
              wword_q     <= '0;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (!bus.sram_busy) begin
            state <= READ_CAP;
            cs_q  <= 1'b0;
            oe_q  <= 1'b0;
          end
        end
        READ_CAP: begin
          rdata_q     <= bus.sram_rdata;
          state       <= DONE;
          rsp_valid_q <= 1'b1;
        end
        DONE: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          set_q       <= '0;
          frame_q     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready       = ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rdata_q;
  assign bus.sram_set_bits   = set_q;
  assign bus.sram_frame_bits = frame_q;
  assign bus.sram_cs         = cs_q;
  assign bus.sram_we         = we_q;
  assign bus.sram_oe         = oe_q;
  assign bus.sram_word_num   = idx_q;
  assign bus.sram_wdata      = wword_q;

  a_we_oe_excl: assert property (@(posedge CLK) disable iff (nRST) !(we_q && oe_q));
  a_set_range:  assert property (@(posedge CLK) disable iff (nRST)
                                 (state == IDLE) || (32'(set_q) < N_SETS));

endmodule

// File: tb/tb_l1_sram_ctrl.sv
// Scoreboard bench for l1_sram_ctrl (8-word blocks, 2 ways) with a behavioural SRAM
// and a per-request reference model of beats, read data and response cycle.
module tb_l1_sram_ctrl;
  import rv32i_types_pkg::*;

  typedef struct {
    bit          we;
    logic [5:0]  set;
    logic        frame;
    logic [2:0]  word;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [255:0] rdata;
    int           cyc;
  } rsp_t;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  l1_sram_ctrl_if #(.N_FRAME_BITS(1), .N_SET_BITS(6), .BLOCK_SIZE(8), .N_BLOCK_BITS(3)) bus ();

  l1_sram_ctrl #(
    .ASSOC(2), .N_FRAME_BITS(1), .N_SETS(64), .N_SET_BITS(6), .BLOCK_SIZE(8), .N_BLOCK_BITS(3)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int nchk = 0, npass = 0, nfail = 0;
  int cyc = 0;
  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  logic [31:0] sram_mem [0:1][0:63][0:7];
  logic [31:0] ref_mem  [0:1][0:63][0:7];
  logic [255:0] last_rdata = '0;
  int  busy_mode = 0;
  bit  toggle_start = 0;
  bit  rd_pending = 0;
  logic [5:0] rd_set;
  logic       rd_frame;
  bit  prev_hold = 0;
  logic [47:0] prev_lines;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else npass++;
  endtask

  function automatic logic [255:0] rand_block();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM wrapper model: busy pattern and read data valid only in the cycle after a read beat.
  always @(posedge CLK) begin
    logic [255:0] blk;
    #1;
    case (busy_mode)
      0:       bus.sram_busy = 1'b0;
      1:       bus.sram_busy = ($urandom_range(0, 2) == 0);
      default: bus.sram_busy = toggle_start ? 1'b1 : !bus.sram_busy;
    endcase
    toggle_start = 0;
    if (rd_pending) begin
      for (int i = 0; i < 8; i++) blk[32*i +: 32] = sram_mem[rd_frame][rd_set][i];
      bus.sram_rdata = blk;
      rd_pending = 0;
    end else bus.sram_rdata = rand_block();
  end

  // Monitor: compares every completed beat and every response against the queues.
  always @(negedge CLK) begin
    logic [47:0] cur;
    beat_t b;
    rsp_t  r;
    if (nRST) begin
      prev_hold = 0;
      rd_pending = 0;
    end else begin
      cur = {bus.sram_cs, bus.sram_we, bus.sram_oe, bus.sram_set_bits, bus.sram_frame_bits,
             bus.sram_word_num, bus.sram_wdata};
      if (prev_hold) chk("beat_stable", cur, prev_lines);
      prev_hold  = bus.sram_cs && bus.sram_busy;
      prev_lines = cur;
      chk("we_oe_excl", bus.sram_we & bus.sram_oe, 0);
      if (bus.req_ready)
        chk("idle_lines", {bus.sram_cs, bus.sram_we, bus.sram_oe, bus.sram_set_bits, bus.sram_frame_bits}, 0);
      if (bus.sram_cs && !bus.sram_busy) begin
        if (beat_q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL beat_unexpected: got lines %0h expected no beat", cur);
        end else begin
          b = beat_q.pop_front();
          chk("beat", {bus.sram_we, bus.sram_oe, bus.sram_set_bits, bus.sram_frame_bits,
                       bus.sram_word_num, b.we ? bus.sram_wdata : 32'h0},
                      {b.we, !b.we, b.set, b.frame, b.word, b.data});
          if (bus.sram_we)
            sram_mem[bus.sram_frame_bits][bus.sram_set_bits][bus.sram_word_num] = bus.sram_wdata;
          else begin
            rd_pending = 1;
            rd_set     = bus.sram_set_bits;
            rd_frame   = bus.sram_frame_bits;
          end
        end
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0");
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, r.rdata);
          if (r.cyc >= 0) chk("rsp_cycle", cyc, r.cyc);
          chk("beats_left", beat_q.size(), 0);
          chk("ready_in_done", bus.req_ready, 0);
        end
      end
    end
  end

  // Issues one request (called at a negedge); the model pushes expectations at acceptance.
  task automatic do_req(input bit wr, input logic [5:0] set, input logic fr, input logic [7:0] mask,
                        input logic [255:0] data, input int mode, input bit hold,
                        output int acc, output int exp_cyc);
    beat_t b;
    rsp_t  r;
    logic [255:0] blk;
    bit ok;
    int k, m;
    bus.req_write = wr;
    bus.req_set   = set;
    bus.req_frame = fr;
    bus.req_wmask = mask;
    bus.req_wdata = data;
    bus.req_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) begin
      nchk++; nfail++;
      $display("FAIL req_accept_timeout: got req_ready=0 for 100 cycles expected 1");
      bus.req_valid = 1'b0;
      acc = -1;
      exp_cyc = -1;
      return;
    end
    busy_mode    = mode;
    toggle_start = (mode == 2);
    m   = (mode == 2) ? 2 : 1;
    acc = cyc + 1;
    k   = 0;
    if (wr) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) begin
          b.we = 1; b.set = set; b.frame = fr; b.word = 3'(i); b.data = data[32*i +: 32];
          beat_q.push_back(b);
          ref_mem[fr][set][i] = data[32*i +: 32];
          k++;
        end
      end
      r.rdata = last_rdata;
      r.cyc   = acc + k * m;
    end else begin
      b.we = 0; b.set = set; b.frame = fr; b.word = 3'd0; b.data = 32'h0;
      beat_q.push_back(b);
      for (int i = 0; i < 8; i++) blk[32*i +: 32] = ref_mem[fr][set][i];
      r.rdata    = blk;
      last_rdata = blk;
      r.cyc      = acc + m + 1;
    end
    if (mode == 1) r.cyc = -1;
    rsp_q.push_back(r);
    exp_cyc = r.cyc;
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int acc1, acc2, e1, e2;
    logic [255:0] d;
    bus.req_valid = 0; bus.req_write = 0; bus.req_set = '0; bus.req_frame = '0;
    bus.req_wmask = '0; bus.req_wdata = '0; bus.sram_busy = 0; bus.sram_rdata = '0;
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 64; s++)
        for (int w = 0; w < 8; w++) begin
          sram_mem[f][s][w] = $urandom;
          ref_mem[f][s][w]  = sram_mem[f][s][w];
        end
    sram_mem[1][5][0] = 32'hAAAA_0000; ref_mem[1][5][0] = 32'hAAAA_0000;
    sram_mem[1][5][1] = 32'hBBBB_0001; ref_mem[1][5][1] = 32'hBBBB_0001;

    repeat (2) @(negedge CLK);
    chk("reset_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rdata", bus.rsp_rdata, 0);
    chk("reset_sram", {bus.sram_cs, bus.sram_we, bus.sram_oe, bus.sram_set_bits,
                       bus.sram_frame_bits, bus.sram_word_num, bus.sram_wdata}, 0);
    #2 nRST = 0;
    @(negedge CLK);

    do_req(0, 6'd5, 1'b1, 8'h00, '0, 0, 0, acc1, e1);
    d = '0;
    d[63:0] = {32'h2222_2222, 32'h1111_1111};
    do_req(1, 6'd10, 1'b0, 8'h03, d, 2, 0, acc1, e1);
    do_req(1, 6'd20, 1'b1, 8'hA4, rand_block(), 0, 0, acc1, e1);
    do_req(1, 6'd21, 1'b0, 8'h00, rand_block(), 0, 0, acc1, e1);

    // Valid held across two requests: second accept must wait for DONE plus one idle cycle.
    do_req(1, 6'd30, 1'b1, 8'h81, rand_block(), 0, 1, acc1, e1);
    do_req(0, 6'd10, 1'b0, 8'hFF, rand_block(), 0, 0, acc2, e2);
    chk("b2b_accept_cycle", acc2, e1 + 2);

    // Abort a write mid-beat; set 63 is kept out of every later read.
    do_req(1, 6'd63, 1'b1, 8'hFF, rand_block(), 0, 0, acc1, e1);
    @(negedge CLK);
    #2 nRST = 1;
    #1;
    chk("abort_sram", {bus.sram_cs, bus.sram_we, bus.sram_oe, bus.sram_set_bits,
                       bus.sram_frame_bits, bus.sram_word_num, bus.sram_wdata}, 0);
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    beat_q.delete();
    rsp_q.delete();
    last_rdata = '0;
    busy_mode  = 0;
    @(negedge CLK);
    #2 nRST = 0;
    repeat (4) @(negedge CLK);

    for (int t = 0; t < 60; t++) begin
      do_req($urandom_range(0, 1), 6'($urandom_range(0, 62)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom), rand_block(),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), acc1, e1);
    end
    bus.req_valid = 1'b0;

    for (int n = 0; n < 300 && rsp_q.size() != 0; n++) @(negedge CLK);
    chk("drain_rsp", rsp_q.size(), 0);
    chk("drain_beats", beat_q.size(), 0);
    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
